// File: rtl/vliw_param_engine.sv
// vliw_param_engine
//   Parametrised VLIW iteration engine for one Julia pixel lane. A flop register
//   file of WIDTH-bit signed fixed-point values is updated by a static bundle of
//   five slots (load, neg, add, mul, escape-compare) issued once per cycle after a
//   start pulse, until max_iterations bundles have issued or the compare fires.
//   The multiplier pipeline is then drained before done is raised.
//   Optional feature macro: SAT_ARITH_EN -- when defined, add/neg/mul saturate to
//   the signed WIDTH-bit range; when undefined they wrap (two's complement).
`timescale 1ns/1ps
module vliw_param_engine #(
    parameter int WIDTH   = 27,
    parameter int FRAC    = 23,
    parameter int ADDR_W  = 4,
    parameter int ITER_W  = 10,
    parameter int MUL_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ITER_W-1:0] max_iterations,
    output logic              done,
    output logic [ITER_W-1:0] num_iterations,
    output logic              escaped,
    input  logic              load_enable_input,
    input  logic [WIDTH-1:0]  load_value,
    input  logic [ADDR_W-1:0] load_dest_addr,
    input  logic              neg_enable_input,
    input  logic [ADDR_W-1:0] neg_src_addr,
    input  logic [ADDR_W-1:0] neg_dest_addr,
    input  logic              add_enable_input,
    input  logic [ADDR_W-1:0] add_src1_addr,
    input  logic [ADDR_W-1:0] add_src2_addr,
    input  logic [ADDR_W-1:0] add_dest_addr,
    input  logic              mul_enable_input,
    input  logic [ADDR_W-1:0] mul_src1_addr,
    input  logic [ADDR_W-1:0] mul_src2_addr,
    input  logic [ADDR_W-1:0] mul_dest_addr,
    input  logic              cmp_enable_input,
    input  logic [ADDR_W-1:0] cmp_src_addr,
    input  logic [WIDTH-1:0]  cmp_threshold,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DCW   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

`ifdef SAT_ARITH_EN
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Signed addition, saturating or wrapping depending on build.
    function automatic logic [WIDTH-1:0] add_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SAT_ARITH_EN
        logic [WIDTH:0] sum;
        sum = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (sum[WIDTH] != sum[WIDTH-1]) begin
            return sum[WIDTH] ? MIN_NEG : MAX_POS;
        end else begin
            return sum[WIDTH-1:0];
        end
`else
        return a + b;
`endif
    endfunction

    // Signed negation; the most negative value has no positive twin.
    function automatic logic [WIDTH-1:0] neg_op(input logic [WIDTH-1:0] a);
`ifdef SAT_ARITH_EN
        if (a == MIN_NEG) begin
            return MAX_POS;
        end else begin
            return {WIDTH{1'b0}} - a;
        end
`else
        return {WIDTH{1'b0}} - a;
`endif
    endfunction

    // Fixed-point multiply: full signed product, keep bits [FRAC+WIDTH-1:FRAC].
    function automatic logic [WIDTH-1:0] mul_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] prod;
`ifdef SAT_ARITH_EN
        logic signed [2*WIDTH-1:0] top;
`endif
        prod = $signed(a) * $signed(b);
`ifdef SAT_ARITH_EN
        top = prod >>> (FRAC + WIDTH - 1);
        if ((top != '0) && (top != '1)) begin
            return prod[2*WIDTH-1] ? MIN_NEG : MAX_POS;
        end else begin
            return WIDTH'(prod >>> FRAC);
        end
`else
        return WIDTH'(prod >>> FRAC);
`endif
    endfunction

    state_t                          state_r;
    state_t                          next_state_s;
    logic [WIDTH-1:0]                regs_r [DEPTH];
    logic [ITER_W-1:0]               iter_cnt_r;
    logic [ITER_W-1:0]               max_r;
    logic [ITER_W-1:0]               iter_inc_s;
    logic [DCW-1:0]                  drain_cnt_r;
    logic                            escaped_r;
    logic                            done_r;
    logic                            issue_s;
    logic                            accept_s;
    logic                            cmp_fire_s;
    logic                            load_we_s;
    logic                            neg_we_s;
    logic                            add_we_s;
    logic                            mul_we_s;
    logic [WIDTH-1:0]                neg_res_s;
    logic [WIDTH-1:0]                add_res_s;
    logic [WIDTH-1:0]                mul_res_s;
    logic [MUL_LAT-1:0]              mul_vld_r;
    logic [MUL_LAT-1:0][ADDR_W-1:0]  mul_dst_r;
    logic [MUL_LAT-1:0][WIDTH-1:0]   mul_res_r;
    logic                            mul_ret_s;

    assign iter_inc_s = iter_cnt_r + ITER_W'(1);
    assign neg_res_s  = neg_op(regs_r[neg_src_addr]);
    assign add_res_s  = add_op(regs_r[add_src1_addr], regs_r[add_src2_addr]);
    assign mul_res_s  = mul_op(regs_r[mul_src1_addr], regs_r[mul_src2_addr]);
    assign cmp_fire_s = cmp_enable_input &&
                        ($signed(regs_r[cmp_src_addr]) >= $signed(cmp_threshold));
    assign load_we_s  = issue_s & load_enable_input;
    assign neg_we_s   = issue_s & neg_enable_input;
    assign add_we_s   = issue_s & add_enable_input;
    assign mul_we_s   = issue_s & mul_enable_input;
    assign mul_ret_s  = mul_vld_r[MUL_LAT-1];

    assign done           = done_r;
    assign escaped        = escaped_r;
    assign num_iterations = iter_cnt_r;
    assign rd_data        = regs_r[rd_addr];

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic: run until limit or escape, then drain the multiplier.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    next_state_s = (max_iterations == '0) ? ST_DRAIN : ST_RUN;
                end else begin
                    next_state_s = state_r;
                end
            end
            ST_RUN: begin
                if (cmp_fire_s || (iter_inc_s == max_r)) begin
                    next_state_s = ST_DRAIN;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == DCW'(MUL_LAT - 1)) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM output decode: bundle issue in RUN, start honoured only when idle or done.
    always_comb begin
        issue_s  = 1'b0;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: accept_s = start;
            ST_RUN:           issue_s  = 1'b1;
            ST_DRAIN:         issue_s  = 1'b0;
            default:          issue_s  = 1'b0;
        endcase
    end

    // Run bookkeeping: iteration counter, latched limit, escape flag, done level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            iter_cnt_r <= '0;
            max_r      <= '0;
            escaped_r  <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            if (accept_s) begin
                iter_cnt_r <= '0;
                max_r      <= max_iterations;
                escaped_r  <= 1'b0;
            end else if (issue_s) begin
                iter_cnt_r <= iter_inc_s;
                if (cmp_fire_s) begin
                    escaped_r <= 1'b1;
                end
            end
            done_r <= (next_state_s == ST_DONE);
        end
    end

    // Drain cycle counter, only advances while draining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt_r <= '0;
        end else if (state_r == ST_DRAIN) begin
            drain_cnt_r <= drain_cnt_r + DCW'(1);
        end else begin
            drain_cnt_r <= '0;
        end
    end

    // Multiplier pipeline: product captured at issue, shifted toward retirement.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_vld_r <= '0;
            mul_dst_r <= '0;
            mul_res_r <= '0;
        end else begin
            mul_vld_r[0] <= mul_we_s;
            mul_dst_r[0] <= mul_dest_addr;
            mul_res_r[0] <= mul_res_s;
            for (int k = 1; k < MUL_LAT; k++) begin
                mul_vld_r[k] <= mul_vld_r[k-1];
                mul_dst_r[k] <= mul_dst_r[k-1];
                mul_res_r[k] <= mul_res_r[k-1];
            end
        end
    end

    // Register file writes; later assignments win, giving mul > add > neg > load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            if (load_we_s) begin
                regs_r[load_dest_addr] <= load_value;
            end
            if (neg_we_s) begin
                regs_r[neg_dest_addr] <= neg_res_s;
            end
            if (add_we_s) begin
                regs_r[add_dest_addr] <= add_res_s;
            end
            if (mul_ret_s) begin
                regs_r[mul_dst_r[MUL_LAT-1]] <= mul_res_r[MUL_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_vliw_param_engine.sv
// tb_vliw_param_engine
//   Scoreboard bench: each run's expected result (count, escape flag, latency and
//   the whole register file) comes from an integer reference model and is queued;
//   a monitor pops and compares whenever done rises or a reset probe is requested.
`timescale 1ns/1ps
module tb_vliw_param_engine;

    localparam int WIDTH   = 27;
    localparam int FRAC    = 23;
    localparam int ADDR_W  = 4;
    localparam int ITER_W  = 10;
    localparam int MUL_LAT = 2;
    localparam int DEPTH   = 16;
    localparam longint FULL = 64'sd134217728;
    localparam longint HALF = 64'sd67108864;

    typedef struct packed {
        int                           num;
        bit                           esc;
        bit                           dn;
        int                           start_cyc;
        bit                           probe;
        bit [DEPTH-1:0][WIDTH-1:0]    regs;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ITER_W-1:0] max_iterations;
    logic              done;
    logic [ITER_W-1:0] num_iterations;
    logic              escaped;
    logic              load_enable_input;
    logic [WIDTH-1:0]  load_value;
    logic [ADDR_W-1:0] load_dest_addr;
    logic              neg_enable_input;
    logic [ADDR_W-1:0] neg_src_addr, neg_dest_addr;
    logic              add_enable_input;
    logic [ADDR_W-1:0] add_src1_addr, add_src2_addr, add_dest_addr;
    logic              mul_enable_input;
    logic [ADDR_W-1:0] mul_src1_addr, mul_src2_addr, mul_dest_addr;
    logic              cmp_enable_input;
    logic [ADDR_W-1:0] cmp_src_addr;
    logic [WIDTH-1:0]  cmp_threshold;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;

    exp_t   sb[$];
    int     compared     = 0;
    int     mismatched   = 0;
    int     cyc          = 0;
    int     issued       = 0;
    int     checked_runs = 0;
    int     probe_req    = 0;
    int     probe_ack    = 0;
    longint mregs[DEPTH];

    vliw_param_engine #(
        .WIDTH(WIDTH), .FRAC(FRAC), .ADDR_W(ADDR_W), .ITER_W(ITER_W), .MUL_LAT(MUL_LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .max_iterations(max_iterations),
        .done(done), .num_iterations(num_iterations), .escaped(escaped),
        .load_enable_input(load_enable_input), .load_value(load_value), .load_dest_addr(load_dest_addr),
        .neg_enable_input(neg_enable_input), .neg_src_addr(neg_src_addr), .neg_dest_addr(neg_dest_addr),
        .add_enable_input(add_enable_input), .add_src1_addr(add_src1_addr),
        .add_src2_addr(add_src2_addr), .add_dest_addr(add_dest_addr),
        .mul_enable_input(mul_enable_input), .mul_src1_addr(mul_src1_addr),
        .mul_src2_addr(mul_src2_addr), .mul_dest_addr(mul_dest_addr),
        .cmp_enable_input(cmp_enable_input), .cmp_src_addr(cmp_src_addr), .cmp_threshold(cmp_threshold),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model (plain integer arithmetic) ----------------
    function automatic longint sx(input logic [WIDTH-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint fix(input longint x);
`ifdef SAT_ARITH_EN
        if (x > HALF - 1) return HALF - 1;
        if (x < -HALF) return -HALF;
        return x;
`else
        longint y;
        y = x & (FULL - 1);
        if (y >= HALF) y = y - FULL;
        return y;
`endif
    endfunction

    task automatic model_run(input int mx, output int num, output bit esc);
        longint snap[DEPTH];
        longint pv[int];
        int     pd[int];
        bit     fire;
        num = 0;
        esc = 1'b0;
        for (int c = 1; c <= mx; c++) begin
            snap = mregs;
            if (mul_enable_input) begin
                pv[c] = fix((snap[mul_src1_addr] * snap[mul_src2_addr]) >>> FRAC);
                pd[c] = int'(mul_dest_addr);
            end
            fire = cmp_enable_input && (snap[cmp_src_addr] >= sx(cmp_threshold));
            if (load_enable_input) mregs[load_dest_addr] = sx(load_value);
            if (neg_enable_input)  mregs[neg_dest_addr]  = fix(-snap[neg_src_addr]);
            if (add_enable_input)  mregs[add_dest_addr]  = fix(snap[add_src1_addr] + snap[add_src2_addr]);
            if (pv.exists(c - MUL_LAT)) mregs[pd[c - MUL_LAT]] = pv[c - MUL_LAT];
            num = c;
            if (fire) begin
                esc = 1'b1;
                break;
            end
        end
        for (int c = num + 1; c <= num + MUL_LAT; c++) begin
            if (pv.exists(c - MUL_LAT)) mregs[pd[c - MUL_LAT]] = pv[c - MUL_LAT];
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic clear_slots();
        load_enable_input = 1'b0; load_value = '0; load_dest_addr = '0;
        neg_enable_input = 1'b0; neg_src_addr = '0; neg_dest_addr = '0;
        add_enable_input = 1'b0; add_src1_addr = '0; add_src2_addr = '0; add_dest_addr = '0;
        mul_enable_input = 1'b0; mul_src1_addr = '0; mul_src2_addr = '0; mul_dest_addr = '0;
        cmp_enable_input = 1'b0; cmp_src_addr = '0; cmp_threshold = '0;
    endtask

    task automatic do_run(input int mx);
        exp_t e;
        int   num;
        bit   esc;
        int   budget;
        @(negedge clk);
        max_iterations = ITER_W'(mx);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.start_cyc = cyc;
        model_run(mx, num, esc);
        e.num = num; e.esc = esc; e.dn = 1'b1; e.probe = 1'b0;
        for (int i = 0; i < DEPTH; i++) e.regs[i] = mregs[i][WIDTH-1:0];
        sb.push_back(e);
        issued++;
        budget = mx + MUL_LAT + 60;
        while ((checked_runs != issued) && (budget > 0)) begin
            @(posedge clk);
            budget--;
        end
        chk("run_complete", 64'(checked_runs), 64'(issued));
        if (checked_runs != issued) begin
            sb.delete();
            issued = checked_runs;
        end
    endtask

    // Expects reset to be held low on entry; releases it afterwards.
    task automatic reset_probe();
        exp_t e;
        int   budget;
        e = '0;
        e.probe = 1'b1;
        sb.push_back(e);
        probe_req++;
        budget = 100;
        while ((probe_ack != probe_req) && (budget > 0)) begin
            @(posedge clk);
            budget--;
        end
        chk("probe_complete", 64'(probe_ack), 64'(probe_req));
        if (probe_ack != probe_req) begin
            sb.delete();
            probe_req = probe_ack;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) mregs[i] = 0;
    endtask

    task automatic randomize_slots();
        load_enable_input = 1'($urandom_range(0, 1));
        load_value        = WIDTH'($urandom);
        load_dest_addr    = ADDR_W'($urandom);
        neg_enable_input  = 1'($urandom_range(0, 1));
        neg_src_addr      = ADDR_W'($urandom);
        neg_dest_addr     = ADDR_W'($urandom);
        add_enable_input  = 1'($urandom_range(0, 1));
        add_src1_addr     = ADDR_W'($urandom);
        add_src2_addr     = ADDR_W'($urandom);
        add_dest_addr     = ADDR_W'($urandom);
        mul_enable_input  = 1'($urandom_range(0, 1));
        mul_src1_addr     = ADDR_W'($urandom);
        mul_src2_addr     = ADDR_W'($urandom);
        mul_dest_addr     = ADDR_W'($urandom);
        cmp_enable_input  = 1'($urandom_range(0, 1));
        cmp_src_addr      = ADDR_W'($urandom);
        cmp_threshold     = WIDTH'($urandom);
    endtask

    initial begin : stimulus
        reset = 1'b0;
        start = 1'b0;
        max_iterations = '0;
        clear_slots();
        for (int i = 0; i < DEPTH; i++) mregs[i] = 0;
        repeat (3) @(negedge clk);
        reset_probe();

        // load 123 -> r1, neg r1 -> r2, long run to the limit
        clear_slots();
        load_enable_input = 1'b1; load_value = 27'd123; load_dest_addr = 4'd1;
        neg_enable_input = 1'b1; neg_src_addr = 4'd1; neg_dest_addr = 4'd2;
        do_run(1000);

        // 1.5 * 1.5 -> r3
        clear_slots();
        load_enable_input = 1'b1; load_value = 27'h0C00000; load_dest_addr = 4'd1;
        mul_enable_input = 1'b1; mul_src1_addr = 4'd1; mul_src2_addr = 4'd1; mul_dest_addr = 4'd3;
        do_run(4);

        // accumulate 1.0 into r4 until r4 >= 4.0
        clear_slots();
        load_enable_input = 1'b1; load_value = 27'h0800000; load_dest_addr = 4'd1;
        add_enable_input = 1'b1; add_src1_addr = 4'd1; add_src2_addr = 4'd4; add_dest_addr = 4'd4;
        cmp_enable_input = 1'b1; cmp_src_addr = 4'd4; cmp_threshold = 27'h2000000;
        do_run(1000);

        // load and add collide on r5, then a zero-length run
        clear_slots();
        load_enable_input = 1'b1; load_value = 27'd7; load_dest_addr = 4'd5;
        add_enable_input = 1'b1; add_src1_addr = 4'd0; add_src2_addr = 4'd0; add_dest_addr = 4'd5;
        do_run(1);
        do_run(0);

        // 3.0 * 3.0 overflows the format
        clear_slots();
        load_enable_input = 1'b1; load_value = 27'h1800000; load_dest_addr = 4'd1;
        mul_enable_input = 1'b1; mul_src1_addr = 4'd1; mul_src2_addr = 4'd1; mul_dest_addr = 4'd2;
        do_run(3);

        // negate the most negative value, and counter at its top limit
        clear_slots();
        load_enable_input = 1'b1; load_value = 27'h4000000; load_dest_addr = 4'd6;
        neg_enable_input = 1'b1; neg_src_addr = 4'd6; neg_dest_addr = 4'd7;
        do_run(1023);

        // abort a run with reset around bundle 50, then run fresh
        clear_slots();
        load_enable_input = 1'b1; load_value = 27'd5; load_dest_addr = 4'd7;
        add_enable_input = 1'b1; add_src1_addr = 4'd7; add_src2_addr = 4'd8; add_dest_addr = 4'd8;
        mul_enable_input = 1'b1; mul_src1_addr = 4'd7; mul_src2_addr = 4'd7; mul_dest_addr = 4'd9;
        @(negedge clk);
        max_iterations = 10'd1000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        reset = 1'b0;
        reset_probe();
        do_run(20);

        for (int r = 0; r < 25; r++) begin
            randomize_slots();
            do_run(int'($urandom_range(0, 40)));
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic check_entry(input exp_t e);
        chk("done", 64'(done), 64'(e.dn));
        chk("num_iterations", 64'(num_iterations), 64'(e.num));
        chk("escaped", 64'(escaped), 64'(e.esc));
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = ADDR_W'(i);
            #0.2;
            chk($sformatf("reg[%0d]", i), 64'(rd_data), 64'(e.regs[i]));
        end
    endtask

    initial begin : monitor
        bit   prev_done;
        exp_t e;
        prev_done = 1'b0;
        rd_addr = '0;
        forever begin
            @(negedge clk);
            if (probe_req != probe_ack) begin
                if (sb.size() == 0) begin
                    chk("probe_without_expectation", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check_entry(e);
                end
                probe_ack++;
            end else if ((done === 1'b1) && !prev_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("latency", 64'(cyc - e.start_cyc), 64'(e.num + MUL_LAT));
                    check_entry(e);
                end
                checked_runs++;
            end
            prev_done = (done === 1'b1);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "bench did not finish");
    end

endmodule
